// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer slave types, Wishbone CTI codes and test-pattern helper
package fb_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } fb_state_t;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] END     = 3'b111;

    localparam logic [31:0] COLOR_WHITE = 32'h00FF_FFFF;
    localparam logic [31:0] COLOR_BLACK = 32'h0000_0000;

    // Grid every 16 pixels in both directions.
    function automatic logic [31:0] fb_pattern(input logic [15:0] x, input logic [15:0] y);
        return ((x[3:0] == 4'd0) || (y[3:0] == 4'd0)) ? COLOR_WHITE : COLOR_BLACK;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - Wishbone B4 bus bundle with master and slave views
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (output cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    input  dat_sm, ack, err, rty);
    modport slave  (input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    output dat_sm, ack, err, rty);
endinterface

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - single-port 32-bit RAM with byte enables and registered read
module fb_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wshb_fb_slave.sv
// rtl/wshb_fb_slave.sv - Wishbone framebuffer slave, self-filled with a grid pattern
// Optional incrementing-burst support is compiled in with WSHB_BURST_EN.
module wshb_fb_slave
    import fb_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic   clk,
    input  logic   rst_n,
    wshb_if.slave  wshb_ifs
);

    localparam int N  = HDISP * VDISP;
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] FILL_LAST = AW'(N - 1);

    fb_state_t     state, state_nx;
    logic [AW-1:0] fill_cnt;
    logic [15:0]   fill_x, fill_y;
    logic [29:0]   idx_q, idx_nx, req_idx;
    logic          we_q, burst_q;
    logic          req, idx_ok, ack, err;
    logic [31:0]   dat_hold, dat_sm;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata, ram_rdata;

    logic unused_bits;
    assign unused_bits = ^{wshb_ifs.bte, wshb_ifs.adr[1:0], wshb_ifs.cti};

    assign req     = wshb_ifs.cyc & wshb_ifs.stb;
    assign req_idx = wshb_ifs.adr[31:2];
    assign idx_nx  = idx_q + 30'd1;
    assign idx_ok  = idx_q < 30'(N);

    // Acknowledges follow the live strobe so an abandoned cycle is never answered.
    assign ack = rst_n && (state == RESP) && req && idx_ok;
    assign err = rst_n && (state == RESP) && req && !idx_ok;

    always_comb begin
        if (!rst_n)
            dat_sm = 32'd0;
        else if (ack && !we_q)
            dat_sm = ram_rdata;
        else if (err)
            dat_sm = 32'd0;
        else
            dat_sm = dat_hold;
    end

    assign wshb_ifs.ack    = ack;
    assign wshb_ifs.err    = err;
    assign wshb_ifs.rty    = 1'b0;
    assign wshb_ifs.dat_sm = dat_sm;

    always_comb begin
        state_nx  = state;
        ram_addr  = fill_cnt;
        ram_we    = 1'b0;
        ram_be    = 4'hF;
        ram_wdata = fb_pattern(fill_x, fill_y);
        case (state)
            FILL: begin
                ram_we = 1'b1;
                if (fill_cnt == FILL_LAST)
                    state_nx = IDLE;
            end
            IDLE: begin
                // Issue the read early so data is ready in the response cycle.
                ram_addr = req_idx[AW-1:0];
                if (req)
                    state_nx = RESP;
            end
            RESP: begin
                ram_addr  = idx_q[AW-1:0];
                ram_be    = wshb_ifs.sel;
                ram_wdata = wshb_ifs.dat_ms;
                ram_we    = we_q && ack;
                state_nx  = IDLE;
                if (burst_q && ack && (wshb_ifs.cti != END)) begin
                    state_nx = RESP;
                    if (!we_q)
                        ram_addr = idx_nx[AW-1:0];
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FILL;
            fill_cnt <= '0;
            fill_x   <= '0;
            fill_y   <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            burst_q  <= 1'b0;
            dat_hold <= '0;
        end else begin
            state    <= state_nx;
            dat_hold <= dat_sm;
            if (state == FILL) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_x == 16'(HDISP - 1)) begin
                    fill_x <= '0;
                    fill_y <= fill_y + 16'd1;
                end else begin
                    fill_x <= fill_x + 16'd1;
                end
            end
            if (state == IDLE && req) begin
                idx_q <= req_idx;
                we_q  <= wshb_ifs.we;
`ifdef WSHB_BURST_EN
                burst_q <= (wshb_ifs.cti == INCR);
`else
                burst_q <= 1'b0;
`endif
            end
            if (state == RESP && ack)
                idx_q <= idx_nx;
        end
    end

    fb_ram #(.DEPTH(N), .AW(AW)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_wshb_fb_slave.sv
// tb/tb_wshb_fb_slave.sv - self-checking bench for wshb_fb_slave (16x8 framebuffer)
module tb_wshb_fb_slave;

    localparam int HD = 16;
    localparam int VD = 8;
    localparam int N  = HD * VD;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wshb_if wb ();

    wshb_fb_slave #(.HDISP(HD), .VDISP(VD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wshb_ifs (wb)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] ref_mem [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_pat(input int i);
        int x, y;
        x = i % HD;
        y = i / HD;
        return ((x % 16) == 0 || (y % 16) == 0) ? 32'h00FF_FFFF : 32'h0;
    endfunction

    task automatic ref_refill();
        for (int i = 0; i < N; i++) ref_mem[i] = ref_pat(i);
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic ack_o, output logic err_o,
                        output logic [31:0] dat_o, output int waited);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = w; wb.adr = a;
        wb.sel = s; wb.dat_ms = d; wb.cti = 3'b000;
        waited = 0;
        while (waited < 400) begin
            @(negedge clk);
            if (wb.ack || wb.err) break;
            waited++;
        end
        ack_o = wb.ack; err_o = wb.err; dat_o = wb.dat_sm;
        @(posedge clk); #1;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    logic        a, e, w;
    logic [31:0] d, wd, addr;
    logic [3:0]  s;
    int          n, idx;

    initial begin
        wb.cyc = 0; wb.stb = 0; wb.we = 0; wb.adr = 0; wb.sel = 0;
        wb.dat_ms = 0; wb.cti = 0; wb.bte = 0;
        rst_n = 1'b0;
        ref_refill();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", {31'd0, wb.ack}, 32'd0);
        check("reset_err", {31'd0, wb.err}, 32'd0);
        check("reset_rty", {31'd0, wb.rty}, 32'd0);
        check("reset_dat", wb.dat_sm, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // A read held from reset release stalls through the whole fill.
        xfer(1'b0, 32'h0, 4'hF, 32'h0, a, e, d, n);
        check("fill_stall_min", 32'(n >= N), 32'd1);
        check("fill_stall_max", 32'(n <= N + 2), 32'd1);
        check("fill_read_ack", {31'd0, a}, 32'd1);
        check("fill_read_dat", d, 32'h00FF_FFFF);

        xfer(1'b0, 32'h14, 4'hF, 32'h0, a, e, d, n);
        check("rd14_latency", n, 32'd1);
        check("rd14_dat", d, 32'h00FF_FFFF);
        @(negedge clk);
        check("dat_hold", wb.dat_sm, 32'h00FF_FFFF);
        @(posedge clk); #1;
        xfer(1'b0, 32'h44, 4'hF, 32'h0, a, e, d, n);
        check("rd44_dat", d, 32'h0);

        xfer(1'b1, 32'h44, 4'b0010, 32'hAABB_CCDD, a, e, d, n);
        check("wr44_ack", {31'd0, a}, 32'd1);
        ref_mem[17] = 32'h0000_CC00;
        xfer(1'b0, 32'h44, 4'hF, 32'h0, a, e, d, n);
        check("wr44_readback", d, 32'h0000_CC00);

        // Out-of-range index aliases RAM word 0 if truncated; it must not land there.
        xfer(1'b1, 32'h200, 4'hF, 32'hDEAD_BEEF, a, e, d, n);
        check("wr200_err", {30'd0, a, e}, 32'd1);
        xfer(1'b0, 32'h200, 4'hF, 32'h0, a, e, d, n);
        check("rd200_ack_err", {30'd0, a, e}, 32'd1);
        check("rd200_dat", d, 32'h0);
        xfer(1'b0, 32'h0, 4'hF, 32'h0, a, e, d, n);
        check("rd0_unchanged", d, ref_mem[0]);

        // Master abandons the cycle while the slave is in its response state.
        wb.cyc = 1; wb.stb = 1; wb.we = 0; wb.adr = 32'h14;
        @(posedge clk); #1;
        wb.cyc = 0; wb.stb = 0;
        @(negedge clk);
        check("drop_no_ack", {30'd0, wb.ack, wb.err}, 32'd0);
        @(posedge clk); #1;

        for (int k = 0; k < 40; k++) begin
            idx  = int'($urandom_range(0, N + 11));
            w    = 1'($urandom_range(0, 1));
            s    = 4'($urandom);
            wd   = $urandom;
            addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
            xfer(w, addr, s, wd, a, e, d, n);
            if (idx < N) begin
                check("rnd_ack", {30'd0, a, e}, 32'd2);
                if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
                end else begin
                    check("rnd_rd_dat", d, ref_mem[idx]);
                end
            end else begin
                check("rnd_err", {30'd0, a, e}, 32'd1);
                if (!w) check("rnd_err_dat", d, 32'h0);
            end
        end

        // Reset pulse while a read is in its response cycle aborts it and refills.
        wb.cyc = 1; wb.stb = 1; wb.we = 0; wb.adr = 32'h44; wb.sel = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_resp_no_ack", {30'd0, wb.ack, wb.err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_refill();
        xfer(1'b0, 32'h44, 4'hF, 32'h0, a, e, d, n);
        check("refill_stall_min", 32'(n >= N), 32'd1);
        check("refill_stall_max", 32'(n <= N + 2), 32'd1);
        check("refill_dat", d, ref_mem[17]);

`ifdef WSHB_BURST_EN
        wb.cyc = 1; wb.stb = 1; wb.we = 0; wb.adr = 32'h38; wb.cti = 3'b010;
        n = 0;
        for (int beat = 0; beat < 4; beat++) begin
            if (beat == 3) wb.cti = 3'b111;
            while (n < 20) begin
                @(negedge clk);
                if (wb.ack || wb.err) break;
                n++;
            end
            check("burst_dat", wb.dat_sm, ref_mem[14 + beat]);
            @(posedge clk); #1;
        end
        check("burst_gaps", n, 32'd1);
        wb.cyc = 0; wb.stb = 0; wb.cti = 3'b000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
